spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- Shares the single SPI master (16-bit frame, wrt/done handshake, 16-bit returned data) among NUM_REQ requesters, e.g. gyro polling, accel polling and config writes.
- Grants the bus round-robin, launches one frame per grant, and returns the response with a one-cycle ack.
- Sits between the SPI master and the sensor-interface blocks; it is the only driver of the master's wrt and cmd inputs.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- CMD_W, 16, SPI frame width; must match the SPI master
- TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- cmd  in  NUM_REQ*CMD_W  packed commands; requester i drives bits [i*CMD_W +: CMD_W]
- ack  out  NUM_REQ  one-hot completion pulse, one cycle
- rsp_data  out  CMD_W  captured response, valid when ack is high
- gnt_idx  out  3  index of the current or last granted requester
- busy  out  1  high in every state except IDLE
- spi_wrt  out  1  start pulse to the SPI master
- spi_cmd  out  CMD_W  frame to the SPI master
- spi_done  in  1  frame-complete pulse from the SPI master
- spi_data  in  CMD_W  returned frame from the SPI master
- err  out  1  timeout pulse (only with SPI_ARB_TIMEOUT_EN)

Behaviour:
- Interface rules:
  - Clock and reset: one clock, clk. Reset is synchronous and active-high, named rst.
  - Requester contract: hold req high and cmd stable until its ack. Drop req in the cycle after ack unless another transaction is wanted.
- Reset values:
  - state is IDLE.
  - ack, spi_wrt, busy and err are 0.
  - spi_cmd and rsp_data are 0.
  - Round-robin pointer is NUM_REQ-1, so requester 0 wins first; gnt_idx is NUM_REQ-1.
- IDLE:
  - If any req bit is high, select the first set bit searching from pointer+1, wrapping modulo NUM_REQ.
  - Register that index into gnt_idx and the pointer, register its cmd slice into spi_cmd, then go to ISSUE.
  - If no req bit is high, stay in IDLE.
- ISSUE: spi_wrt = 1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - Stay until spi_done = 1.
  - On spi_done, capture spi_data into rsp_data and go to ACK.
- ACK: ack[gnt_idx] = 1 for one cycle, then go to IDLE.
- Latency: req seen in IDLE at cycle N gives spi_wrt at N+1. spi_done at cycle M gives ack at M+1.
- Minimum gap between frames is 2 cycles (ACK, then IDLE). This satisfies the master's own DONE-then-IDLE recovery.
- spi_cmd is held constant from IDLE exit until the next grant.
- rsp_data holds its value until the next capture.
- Boundary conditions:
  - spi_done in IDLE, ISSUE or ACK: ignored.
  - req deasserted mid-transaction: the frame completes and ack is still pulsed.
  - Multiple simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ-1 frames.
  - A requester that re-asserts req immediately after its ack is served only after every other pending requester.
  - rst asserted in any state: return to reset values on the next edge, no ack is issued, and any in-flight frame is abandoned. The SPI master shares the same reset source.
  - Index computation: NUM_REQ is not required to be a power of two, so the wrap uses explicit compare-and-reset, not bit truncation.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - On reaching TIMEOUT_CYC-1 without spi_done, go to ACK with rsp_data = all ones and err = 1 for the ACK cycle.
  - Requester and pointer behaviour is unchanged.
- Without the macro: the err port and the counter are absent, and WAIT waits indefinitely.

Test Plan:
- Single request: after reset, req=3'b001, cmd0=16'hA5C3.
  - spi_wrt pulses once with spi_cmd=16'hA5C3.
  - Model returns spi_data=16'h1234 with spi_done 40 cycles later.
  - Next cycle: ack=3'b001, rsp_data=16'h1234, busy falls the following cycle.
- Round-robin: req=3'b111 held with re-assertion after each ack.
  - Grant order is 0,1,2,0,1,2.
  - Exactly one spi_wrt per frame.
  - At least 2 idle cycles between done and the next wrt.
- Back-to-back fairness: req0 re-asserts immediately while req2 is pending.
  - Grant order is 0,2,0; req0 is never served twice in a row.
- Spurious done: spi_done pulsed while in IDLE with no req.
  - No ack, no spi_wrt, state remains IDLE.
- Reset mid-frame: rst=1 for one cycle during WAIT.
  - ack stays 0, all outputs return to reset values, gnt_idx=NUM_REQ-1.
  - Next req=3'b010 is granted to requester 1.
- Timeout (macro on, TIMEOUT_CYC=16): no spi_done after grant.
  - At 16 cycles into WAIT: ack pulse to the granted requester, rsp_data=16'hFFFF, err=1 for one cycle.
  - The arbiter then returns to IDLE.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters, one frame per grant.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT watchdog that completes the frame with all-ones data and pulses err.
module spi_bus_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int CMD_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CMD_W-1:0] cmd,
  output logic [NUM_REQ-1:0]       ack,
  output logic [CMD_W-1:0]         rsp_data,
  output logic [2:0]               gnt_idx,
  output logic                     busy,
  output logic                     spi_wrt,
  output logic [CMD_W-1:0]         spi_cmd,
  input  logic                     spi_done,
  input  logic [CMD_W-1:0]         spi_data
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic                     err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t           state, state_nxt;
  logic             found;
  logic [2:0]       sel;
  logic [CMD_W-1:0] sel_cmd;
  logic             timeout;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt;
  logic             tmo_hit;
  assign timeout = (state == WAIT) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Search starts one past the last grant; the wrap is a compare-and-subtract
  // so non-power-of-two NUM_REQ works.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    sel     = gnt_idx;
    sel_cmd = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(gnt_idx) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          found = 1'b1;
          sel   = 3'(j);
        end
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (sel == 3'(j)) sel_cmd = cmd[j*CMD_W +: CMD_W];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (spi_done || timeout) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    spi_wrt = (state == ISSUE);
    ack     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state == ACK) && (gnt_idx == 3'(i));
    end
`ifdef SPI_ARB_TIMEOUT_EN
    err = (state == ACK) && tmo_hit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_idx  <= 3'(NUM_REQ - 1);
      spi_cmd  <= '0;
      rsp_data <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt      <= '0;
      tmo_hit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx <= sel;
            spi_cmd <= sel_cmd;
          end
        end
        ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
          cnt     <= '0;
          tmo_hit <= 1'b0;
`endif
        end
        WAIT: begin
          if (spi_done) begin
            rsp_data <= spi_data;
          end else if (timeout) begin
            rsp_data <= '1;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_hit  <= 1'b1;
`endif
          end
`ifdef SPI_ARB_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (3 requesters, 16-bit frames, watchdog of 16 when enabled).
module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [47:0] cmd;
  logic [2:0]  ack;
  logic [15:0] rsp_data;
  logic [2:0]  gnt_idx;
  logic        busy;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done = 1'b0;
  logic [15:0] spi_data = '0;
`ifdef SPI_ARB_TIMEOUT_EN
  logic        err;
`endif

  localparam logic [15:0] C0 = 16'hA5C3;
  localparam logic [15:0] C1 = 16'h0B11;
  localparam logic [15:0] C2 = 16'h0C22;

  int total   = 0;
  int bad     = 0;
  int wrt_cnt = 0;

  assign cmd = {C2, C1, C0};

  spi_bus_arbiter #(.NUM_REQ(3), .CMD_W(16), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .ack(ack), .rsp_data(rsp_data),
    .gnt_idx(gnt_idx), .busy(busy), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_data(spi_data)
`ifdef SPI_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (spi_wrt === 1'b1) wrt_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expCmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return C0;
      3'd1:    return C1;
      default: return C2;
    endcase
  endfunction

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt_idx), 32'd2);
  endtask

  // One full frame: wait for the grant, answer after wait_cyc WAIT cycles, check ack.
  task automatic frame(input logic [2:0] exp_idx, input logic [15:0] rdata,
                       input int wait_cyc, input bit chk_gap);
    int n;
    int w0;
    n  = 0;
    w0 = wrt_cnt;
    while (spi_wrt !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wrt_seen", 32'(spi_wrt), 32'd1);
    if (chk_gap) chk("gap_cycles", 32'(n), 32'd2);
    chk("gnt_idx", 32'(gnt_idx), 32'(exp_idx));
    chk("spi_cmd", 32'(spi_cmd), 32'(expCmd(exp_idx)));
    tick();
    chk("wrt_one_cycle", 32'(spi_wrt), 32'd0);
    repeat (wait_cyc) tick();
    chk("no_early_ack", 32'(ack), 32'd0);
    spi_done = 1'b1;
    spi_data = rdata;
    tick();
    spi_done = 1'b0;
    chk("ack_onehot", 32'(ack), 32'(3'b001 << exp_idx));
    chk("rsp_data", 32'(rsp_data), 32'(rdata));
    chk("wrt_count", 32'(wrt_cnt - w0), 32'd1);
  endtask

  initial begin
    tick();
    doReset();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wrt", 32'(spi_wrt), 32'd0);
    chk("rst_cmd", 32'(spi_cmd), 32'd0);
    chk("rst_rsp", 32'(rsp_data), 32'd0);

    // Single request; req dropped mid-frame still gets its ack.
    req = 3'b001;
    tick();
    chk("t1_wrt", 32'(spi_wrt), 32'd1);
    chk("t1_cmd", 32'(spi_cmd), 32'hA5C3);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    req = 3'b000;
    repeat (38) tick();
    chk("t1_wait_ack", 32'(ack), 32'd0);
    spi_done = 1'b1;
    spi_data = 16'h1234;
    tick();
    spi_done = 1'b0;
    chk("t1_ack", 32'(ack), 32'b001);
    chk("t1_rsp", 32'(rsp_data), 32'h1234);
    chk("t1_busy_ack", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_ack_clr", 32'(ack), 32'd0);
    chk("t1_rsp_hold", 32'(rsp_data), 32'h1234);

    // Spurious done in IDLE is ignored.
    spi_done = 1'b1;
    spi_data = 16'hDEAD;
    tick();
    spi_done = 1'b0;
    chk("sp_ack", 32'(ack), 32'd0);
    chk("sp_wrt", 32'(spi_wrt), 32'd0);
    chk("sp_busy", 32'(busy), 32'd0);
    tick();
    chk("sp_busy2", 32'(busy), 32'd0);
    chk("sp_rsp", 32'(rsp_data), 32'h1234);

    // Reset during WAIT abandons the frame without an ack.
    req = 3'b001;
    tick();
    chk("rm_wrt", 32'(spi_wrt), 32'd1);
    repeat (3) tick();
    req = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_ack", 32'(ack), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_gnt", 32'(gnt_idx), 32'd2);
    chk("rm_cmd", 32'(spi_cmd), 32'd0);
    chk("rm_rsp", 32'(rsp_data), 32'd0);
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    chk("rm_ack2", 32'(ack), 32'd0);
    req = 3'b010;
    frame(3'd1, 16'h5151, 5, 1'b0);
    req = 3'b000;
    tick();

    // Round-robin with all requests held.
    doReset();
    req = 3'b111;
    frame(3'd0, 16'h1000, 3, 1'b0);
    frame(3'd1, 16'h1001, 4, 1'b1);
    frame(3'd2, 16'h1002, 0, 1'b1);
    frame(3'd0, 16'h1003, 7, 1'b1);
    frame(3'd1, 16'h1004, 1, 1'b1);
    frame(3'd2, 16'h1005, 2, 1'b1);
    req = 3'b000;
    tick();

    // Fairness: req0 re-asserts while req2 is pending.
    doReset();
    req = 3'b101;
    frame(3'd0, 16'h2000, 2, 1'b0);
    frame(3'd2, 16'h2002, 2, 1'b1);
    frame(3'd0, 16'h2004, 2, 1'b1);
    req = 3'b000;
    tick();
    chk("fair_idle", 32'(busy), 32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: no done after the grant.
    doReset();
    req = 3'b100;
    tick();
    chk("to_wrt", 32'(spi_wrt), 32'd1);
    chk("to_gnt", 32'(gnt_idx), 32'd2);
    req = 3'b000;
    repeat (16) tick();
    chk("to_pre_ack", 32'(ack), 32'd0);
    chk("to_pre_err", 32'(err), 32'd0);
    tick();
    chk("to_ack", 32'(ack), 32'b100);
    chk("to_rsp", 32'(rsp_data), 32'hFFFF);
    chk("to_err", 32'(err), 32'd1);
    tick();
    chk("to_err_clr", 32'(err), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
